j11_intc: RTL and testbench
===========================

# j11_intc

Parametrised interrupt controller for the DCJ11 bus bridge. It generalises the fixed UART/RL/KW interrupt handling to NIRQ sources, each with a compile-time vector and bus request level. It latches source events, drives the four J11 IRQ request lines, and answers interrupt-acknowledge cycles with the winning source's vector. It sits between the peripheral interrupt outputs and the bus bridge's IACK decode.

## Interface
- NIRQ, 8: number of interrupt sources, 1..16.
- VECTORS, {NIRQ{16'o0}}: packed NIRQ×16. Slice i is the vector of source i; bits [1:0] must be 0.
- LEVELS, {NIRQ{2'd0}}: packed NIRQ×2. Slice i selects which j11irq bit (0..3) source i requests on.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- irq  in  NIRQ  one-cycle event pulses from the peripherals.
- iackreq  in  1  one-cycle IACK request strobe from the bus bridge.
- iacklvl  in  4  one-hot level being acknowledged (busaddr[3:0] of the IACK cycle).
- iackack  out  1  one-cycle acknowledge.
- iackdata  out  16  returned vector.
- iacknone  out  1  qualifies iackack: no eligible source was pending.
- j11irq  out  4  registered request lines to the CPU.
- pending  out  NIRQ  current pending bits, for debug.
- regreq  in  1  mask write strobe.
- regwdata  in  32  mask write data.
- regack  out  1  mask write acknowledge.

## Operation
- State:
  - pending[NIRQ], one sticky bit per source.
  - mask[NIRQ], where 1 means enabled.
- Latching: irq[i]=1 sets pending[i].
- Eligibility: a source is eligible when pending[i] and mask[i] are both 1.
- Request lines: j11irq[l] is the OR over eligible sources with LEVELS[i]==l, registered.
- IACK selection:
  - If iacklvl has several bits set, the highest set bit is the level.
  - Among eligible sources at that level, the lowest index wins.
  - iackdata = VECTORS[winner], iacknone = 0, and pending[winner] is cleared.
  - If no source is eligible: iackdata = 0, iacknone = 1, no state change.
  - If iacklvl = 0: iacknone = 1.
- Collision rule: if irq[i] arrives in the same cycle that IACK clears pending[i], the set wins, so pending[i] stays 1 and the event is not lost.
- A second irq[i] pulse while pending[i] is already 1 merges into the existing pending bit (no counting).
- Masked sources still latch pending. Unmasking a source with pending=1 raises its request line one cycle later.
- Mask write: regreq=1 loads mask <= regwdata[NIRQ-1:0]; the upper bits are ignored.

## Timing
- Reset values:
  - pending = 0, mask = all ones.
  - j11irq = 0, iackack = 0, iacknone = 0, iackdata = 0, regack = 0.
- irq to j11irq: 2 cycles. The cycle after the pulse, pending is set; the cycle after that, j11irq is set.
- iackreq to iackack: 1 cycle.
  - iackdata and iacknone are valid only while iackack=1; they hold their value otherwise.
  - Selection uses the pending/mask values from the request cycle.
- The j11irq line deasserts 2 cycles after the clearing IACK if no other source remains at that level.
- regreq to regack: 1 cycle. The new mask takes effect from the cycle after regreq.
- Back-to-back IACKs on consecutive cycles are legal. The second one sees the bit already cleared by the first.
- rst asserted mid-operation: all pending events are discarded; a concurrent iackreq is not acknowledged.

## Configuration
- J11_INTC_MASK_EN defined:
  - The mask register is implemented and writable as above.
- J11_INTC_MASK_EN undefined:
  - mask is the constant all ones.
  - regack still pulses 1 cycle after regreq; regwdata is ignored.
  - No mask flops are built.

## Structure
- Shared package j11_pkg holds:
  - J11_NLEVEL = 4.
  - J11_VECW = 16.
  - the level type (2-bit).
  - J11_NOVEC = 16'o0.
- Sub-module j11_intc_prio: a combinational lowest-index-first priority encoder. It takes the NIRQ-bit eligible-at-level vector and returns a found flag and the winning index. There is one instance.

## Test plan
Common setup: NIRQ=4, VECTORS={16'o100,16'o160,16'o64,16'o60}, LEVELS={2,1,0,0}.
- Reset, then pulse irq=4'b0001:
  - j11irq=4'b0001 two cycles later.
  - IACK with iacklvl=4'b0001 returns iackdata=16'o60, iacknone=0.
  - j11irq returns to 0 two cycles after the IACK.
- Pulse irq=4'b0011, then IACK at level 0 twice:
  - The first returns 16'o60, the second returns 16'o64.
  - A third returns iacknone=1, iackdata=0.
- Pulse irq=4'b1100:
  - j11irq=4'b0110.
  - IACK with iacklvl=4'b0110 returns 16'o100 (highest level); pending becomes 4'b0100.
- Same-cycle irq[0] and a level-0 IACK clearing source 0:
  - iackdata=16'o60.
  - pending[0] remains 1 and j11irq[0] stays 1.
- Mask (with J11_INTC_MASK_EN):
  - Write mask=4'b1110, then pulse irq[0]: pending[0]=1, j11irq=0, and an IACK at level 0 returns iacknone=1.
  - Write mask=4'hF: j11irq[0]=1 one cycle after regack.
- Assert rst with pending=4'hF and iackreq in the same cycle:
  - No iackack.
  - pending=0, j11irq=0, mask=4'hF.

Source files
------------

// File: rtl/j11_pkg.sv
// rtl/j11_pkg.sv - shared constants and types for the J11 interrupt controller
package j11_pkg;

    localparam int J11_NLEVEL = 4;
    localparam int J11_VECW   = 16;
    localparam logic [J11_VECW-1:0] J11_NOVEC = 16'o0;

    typedef logic [1:0] j11_level_t;

    // Index width that stays legal for a single-source build
    function automatic int j11_idxw(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/j11_intc_prio.sv
// rtl/j11_intc_prio.sv - combinational lowest-index-first priority encoder
module j11_intc_prio
    import j11_pkg::*;
#(
    parameter int N = 8,
    localparam int IW = j11_idxw(N)
) (
    input  logic [N-1:0]  req,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Scanning downward lets the lowest set index overwrite higher ones
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/j11_intc.sv
// rtl/j11_intc.sv - NIRQ-source interrupt controller for the DCJ11 bus bridge; optional mask register under J11_INTC_MASK_EN
module j11_intc
    import j11_pkg::*;
#(
    parameter int NIRQ = 8,
    parameter logic [NIRQ*J11_VECW-1:0] VECTORS = {NIRQ{16'o0}},
    parameter logic [NIRQ*2-1:0]        LEVELS  = {NIRQ{2'd0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NIRQ-1:0]       irq,
    input  logic                  iackreq,
    input  logic [3:0]            iacklvl,
    output logic                  iackack,
    output logic [J11_VECW-1:0]   iackdata,
    output logic                  iacknone,
    output logic [J11_NLEVEL-1:0] j11irq,
    output logic [NIRQ-1:0]       pending,
    input  logic                  regreq,
    input  logic [31:0]           regwdata,
    output logic                  regack
);

    localparam int IW = j11_idxw(NIRQ);

    logic [NIRQ-1:0]       mask;
    logic [NIRQ-1:0]       elig;
    logic [NIRQ-1:0]       at_lvl;
    logic [NIRQ-1:0]       clr;
    logic [J11_NLEVEL-1:0] req_lines;
    j11_level_t            lvl;
    logic                  found;
    logic [IW-1:0]         win;
    logic                  unused_wdata;

    assign elig         = pending & mask;
    assign unused_wdata = ^regwdata;

    // Highest acknowledged level bit wins when the bridge presents several
    always_comb begin
        lvl = '0;
        for (int l = 0; l < J11_NLEVEL; l++) begin
            if (iacklvl[l]) lvl = j11_level_t'(l);
        end
    end

    always_comb begin
        at_lvl    = '0;
        req_lines = '0;
        for (int i = 0; i < NIRQ; i++) begin
            at_lvl[i] = elig[i] && (|iacklvl) && (LEVELS[2*i +: 2] == lvl);
            if (elig[i]) req_lines[LEVELS[2*i +: 2]] = 1'b1;
        end
    end

    j11_intc_prio #(.N(NIRQ)) u_prio (
        .req   (at_lvl),
        .found (found),
        .idx   (win)
    );

    always_comb begin
        clr = '0;
        for (int i = 0; i < NIRQ; i++) begin
            clr[i] = iackreq && found && (win == IW'(i));
        end
    end

    // A new event in the clearing cycle is OR-ed in after the clear so it survives
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            j11irq   <= '0;
            iackack  <= 1'b0;
            iacknone <= 1'b0;
            iackdata <= J11_NOVEC;
            regack   <= 1'b0;
        end else begin
            pending <= (pending & ~clr) | irq;
            j11irq  <= req_lines;
            iackack <= iackreq;
            regack  <= regreq;
            if (iackreq) begin
                iacknone <= !found;
                iackdata <= found ? VECTORS[win*J11_VECW +: J11_VECW] : J11_NOVEC;
            end
        end
    end

`ifdef J11_INTC_MASK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            mask <= '1;
        end else if (regreq) begin
            mask <= regwdata[NIRQ-1:0];
        end
    end
`else
    assign mask = '1;
`endif

endmodule

// File: tb/tb_j11_intc.sv
// tb/tb_j11_intc.sv - scoreboard bench for j11_intc with NIRQ=4
module tb_j11_intc;

    typedef struct packed {
        logic [15:0] data;
        logic        none;
    } iack_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  irq;
    logic        iackreq;
    logic [3:0]  iacklvl;
    logic        iackack;
    logic [15:0] iackdata;
    logic        iacknone;
    logic [3:0]  j11irq;
    logic [3:0]  pending;
    logic        regreq;
    logic [31:0] regwdata;
    logic        regack;

    int checks   = 0;
    int failures = 0;
    iack_exp_t exp_q[$];

    j11_intc #(
        .NIRQ    (4),
        .VECTORS ({16'o100, 16'o160, 16'o64, 16'o60}),
        .LEVELS  ({2'd2, 2'd1, 2'd0, 2'd0})
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .irq      (irq),
        .iackreq  (iackreq),
        .iacklvl  (iacklvl),
        .iackack  (iackack),
        .iackdata (iackdata),
        .iacknone (iacknone),
        .j11irq   (j11irq),
        .pending  (pending),
        .regreq   (regreq),
        .regwdata (regwdata),
        .regack   (regack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_irq(input logic [3:0] v);
        irq = v;
        tick();
        irq = '0;
    endtask

    task automatic iack(input logic [3:0] lvl, input logic [15:0] data, input logic none);
        iackreq = 1'b1;
        iacklvl = lvl;
        exp_q.push_back('{data: data, none: none});
        tick();
        iackreq = 1'b0;
        iacklvl = '0;
    endtask

    task automatic mask_write(input logic [31:0] v);
        regreq   = 1'b1;
        regwdata = v;
        tick();
        regreq   = 1'b0;
        check("regack_pulse", {31'd0, regack}, 32'd1);
    endtask

    // Monitor: every acknowledge must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (iackack) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_iackack: got ack with data %0o expected no ack", iackdata);
            end else begin
                iack_exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (iackdata !== e.data || iacknone !== e.none) begin
                    failures++;
                    $display("FAIL iack_resp: got data=%0o none=%0b expected data=%0o none=%0b",
                             iackdata, iacknone, e.data, e.none);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; irq = '0; iackreq = 1'b0; iacklvl = '0; regreq = 1'b0; regwdata = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_j11irq", {28'd0, j11irq}, 32'd0);
        check("rst_pending", {28'd0, pending}, 32'd0);
        check("rst_outs", {13'd0, iackack, iacknone, regack, iackdata}, 32'd0);

        // single source, level 0
        pulse_irq(4'b0001);
        check("t1_pending", {28'd0, pending}, 32'h1);
        check("t1_j11irq_early", {28'd0, j11irq}, 32'h0);
        tick();
        check("t1_j11irq", {28'd0, j11irq}, 32'h1);
        iack(4'b0001, 16'o60, 1'b0);
        check("t1_pending_clr", {28'd0, pending}, 32'h0);
        check("t1_j11irq_hold", {28'd0, j11irq}, 32'h1);
        tick();
        check("t1_j11irq_drop", {28'd0, j11irq}, 32'h0);
        check("t1_data_hold", {16'd0, iackdata}, 32'o60);

        // two sources at level 0, back-to-back IACKs
        pulse_irq(4'b0011);
        tick();
        iack(4'b0001, 16'o60, 1'b0);
        iack(4'b0001, 16'o64, 1'b0);
        iack(4'b0001, 16'o0, 1'b1);
        check("t2_pending", {28'd0, pending}, 32'h0);
        tick();

        // mixed levels, multi-bit iacklvl picks the highest
        pulse_irq(4'b1100);
        tick();
        check("t3_j11irq", {28'd0, j11irq}, 32'h6);
        iack(4'b0110, 16'o100, 1'b0);
        check("t3_pending", {28'd0, pending}, 32'h4);
        iack(4'b0000, 16'o0, 1'b1);
        check("t3_pending_lvl0", {28'd0, pending}, 32'h4);
        iack(4'b0010, 16'o160, 1'b0);
        tick(); tick();
        check("t3_j11irq_idle", {28'd0, j11irq}, 32'h0);

        // set beats clear in the same cycle
        pulse_irq(4'b0001);
        tick();
        irq = 4'b0001;
        iack(4'b0001, 16'o60, 1'b0);
        irq = '0;
        check("t4_pending_kept", {28'd0, pending}, 32'h1);
        tick(); tick();
        check("t4_j11irq_kept", {28'd0, j11irq}, 32'h1);
        iack(4'b0001, 16'o60, 1'b0);
        tick(); tick();
        check("t4_j11irq_idle", {28'd0, j11irq}, 32'h0);

`ifdef J11_INTC_MASK_EN
        mask_write(32'hFFFF_FFFE);
        tick();
        check("m_regack_drop", {31'd0, regack}, 32'd0);
        pulse_irq(4'b0001);
        check("m_pending", {28'd0, pending}, 32'h1);
        tick();
        check("m_j11irq_masked", {28'd0, j11irq}, 32'h0);
        iack(4'b0001, 16'o0, 1'b1);
        mask_write(32'h0000_000F);
        tick();
        check("m_j11irq_unmask", {28'd0, j11irq}, 32'h1);
        iack(4'b0001, 16'o60, 1'b0);
        mask_write(32'h0);
`else
        mask_write(32'h0);
        tick();
        check("m_regack_drop", {31'd0, regack}, 32'd0);
        pulse_irq(4'b0001);
        tick();
        check("m_mask_ignored", {28'd0, j11irq}, 32'h1);
        iack(4'b0001, 16'o60, 1'b0);
`endif
        tick(); tick();

        // reset with everything pending and a concurrent IACK
        pulse_irq(4'b1111);
        check("r_pending_full", {28'd0, pending}, 32'hF);
        rst = 1'b1; iackreq = 1'b1; iacklvl = 4'b0001;
        tick();
        rst = 1'b0; iackreq = 1'b0; iacklvl = '0;
        check("r_no_ack", {31'd0, iackack}, 32'd0);
        check("r_pending", {28'd0, pending}, 32'h0);
        check("r_j11irq", {28'd0, j11irq}, 32'h0);
        pulse_irq(4'b1111);
        tick();
        check("r_mask_all_on", {28'd0, j11irq}, 32'h7);
        tick();

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
